// File: rtl/nodf_module_intf_if.sv
// ap_ctrl_hs handshake bundle between an HLS block (master side) and observers (slave side).
interface nodf_module_intf_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, ap_ready, ap_done, ap_continue);
    modport slave  (input  ap_start, ap_ready, ap_done, ap_continue);
endinterface

// File: rtl/nodf_module_intf.sv
// Passive ap_ctrl_hs status monitor: handshake state, transaction counts, latency statistics.
// Optional protocol checking is enabled with the NODF_PROTOCOL_CHECK_EN macro.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | no transaction tracked
//  ACTIVE    | ap_start seen, inputs not yet accepted (ap_ready pending)
//  WAIT_DONE | inputs accepted, waiting for ap_done & ap_continue
//  FINISHED  | run ended; statistics frozen until reset
module nodf_module_intf #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    nodf_module_intf_if.slave    hs,
    input  logic                 finish,
    output logic [1:0]           status,
    output logic [CNT_W-1:0]     start_cnt,
    output logic [CNT_W-1:0]     done_cnt,
    output logic                 lat_valid,
    output logic [LAT_W-1:0]     last_lat,
    output logic [LAT_W-1:0]     min_lat,
    output logic [LAT_W-1:0]     max_lat,
    output logic                 finish_pulse,
    output logic [2:0]           err
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_DONE = 2'd2,
        FINISHED  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ts;

    logic             accept;
    logic             retire;
    logic             completing;
    logic [CNT_W-1:0] lat_full;
    logic [LAT_W-1:0] lat_now;

    assign accept   = hs.ap_start & hs.ap_ready;
    assign retire   = hs.ap_done & hs.ap_continue;
    assign lat_full = cyc - ts;

    // A start and done in the same IDLE cycle is a zero-latency transaction, not a spurious done.
    always_comb begin
        completing = 1'b0;
        lat_now    = '0;
        if (retire) begin
            case (state)
                ACTIVE, WAIT_DONE: begin
                    completing = 1'b1;
                    lat_now    = LAT_W'(lat_full);
                end
                IDLE: completing = hs.ap_start;
                default: completing = 1'b0;
            endcase
        end
    end

    assign status = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            cyc          <= '0;
            ts           <= '0;
            start_cnt    <= '0;
            done_cnt     <= '0;
            lat_valid    <= 1'b0;
            last_lat     <= '0;
            min_lat      <= '1;
            max_lat      <= '0;
            finish_pulse <= 1'b0;
        end else begin
            cyc          <= (cyc == CNT_MAX) ? cyc : cyc + 1'b1;
            lat_valid    <= 1'b0;
            finish_pulse <= 1'b0;
            if (finish || state == FINISHED) begin
                if (state != FINISHED)
                    finish_pulse <= 1'b1;
                state <= FINISHED;
            end else begin
                if (accept && start_cnt != CNT_MAX)
                    start_cnt <= start_cnt + 1'b1;
                if (completing) begin
                    if (done_cnt != CNT_MAX)
                        done_cnt <= done_cnt + 1'b1;
                    last_lat  <= lat_now;
                    lat_valid <= 1'b1;
                    if (lat_now < min_lat) min_lat <= lat_now;
                    if (lat_now > max_lat) max_lat <= lat_now;
                end
                case (state)
                    IDLE: begin
                        if (hs.ap_start && !retire) begin
                            ts    <= cyc;
                            state <= hs.ap_ready ? WAIT_DONE : ACTIVE;
                        end
                    end
                    ACTIVE, WAIT_DONE: begin
                        if (retire) begin
                            if (hs.ap_start) begin
                                ts    <= cyc;
                                state <= ACTIVE;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (state == ACTIVE && hs.ap_ready && hs.ap_start) begin
                            state <= WAIT_DONE;
                        end
                    end
                    default: state <= FINISHED;
                endcase
            end
        end
    end

`ifdef NODF_PROTOCOL_CHECK_EN
    logic [2:0] err_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            if (state == ACTIVE && !hs.ap_start && !retire)
                err_q[0] <= 1'b1;
            if (state == IDLE && retire && !hs.ap_start)
                err_q[1] <= 1'b1;
            if (start_cnt == CNT_MAX || done_cnt == CNT_MAX || cyc == CNT_MAX)
                err_q[2] <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 3'b000;
`endif
endmodule

// File: tb/tb_nodf_module_intf.sv
// Directed-vector bench for the ap_ctrl_hs status monitor.
module tb_nodf_module_intf;
    logic        clock;
    logic        reset;
    logic        finish;
    logic [1:0]  status;
    logic [31:0] start_cnt;
    logic [31:0] done_cnt;
    logic        lat_valid;
    logic [31:0] last_lat;
    logic [31:0] min_lat;
    logic [31:0] max_lat;
    logic        finish_pulse;
    logic [2:0]  err;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef NODF_PROTOCOL_CHECK_EN
    localparam logic [2:0] ERR_SPUR = 3'b010;
    localparam logic [2:0] ERR_BOTH = 3'b011;
`else
    localparam logic [2:0] ERR_SPUR = 3'b000;
    localparam logic [2:0] ERR_BOTH = 3'b000;
`endif

    nodf_module_intf_if hs ();

    nodf_module_intf #(.CNT_W(32), .LAT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .hs           (hs),
        .finish       (finish),
        .status       (status),
        .start_cnt    (start_cnt),
        .done_cnt     (done_cnt),
        .lat_valid    (lat_valid),
        .last_lat     (last_lat),
        .min_lat      (min_lat),
        .max_lat      (max_lat),
        .finish_pulse (finish_pulse),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of handshake inputs; outputs for that cycle are visible on return.
    task automatic drive(input logic s, input logic r, input logic d, input logic c);
        hs.ap_start    = s;
        hs.ap_ready    = r;
        hs.ap_done     = d;
        hs.ap_continue = c;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        finish = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        finish = 1'b0;
        hs.ap_start = 1'b0; hs.ap_ready = 1'b0; hs.ap_done = 1'b0; hs.ap_continue = 1'b1;

        // reset state
        do_reset();
        chk("rst_status", status, 0);
        chk("rst_start_cnt", start_cnt, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_min_lat", min_lat, 32'hFFFF_FFFF);
        chk("rst_max_lat", max_lat, 0);
        chk("rst_last_lat", last_lat, 0);
        chk("rst_lat_valid", lat_valid, 0);
        chk("rst_finish_pulse", finish_pulse, 0);
        chk("rst_err", err, 0);

        // single transaction, latency 7
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t1_status_wait", status, 2);
        chk("t1_start_cnt", start_cnt, 1);
        idle(6);
        chk("t1_no_valid_early", lat_valid, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_lat_valid", lat_valid, 1);
        chk("t1_last_lat", last_lat, 7);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_status_idle", status, 0);
        chk("t1_min", min_lat, 7);
        chk("t1_max", max_lat, 7);
        idle(1);
        chk("t1_valid_pulse_end", lat_valid, 0);

        // back-to-back: latency 3, then 9 starting in the done cycle
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t2_lat_a", last_lat, 3);
        chk("t2_status_active", status, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t2_status_wait", status, 2);
        idle(7);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_lat_b", last_lat, 9);
        chk("t2_min", min_lat, 3);
        chk("t2_max", max_lat, 9);
        chk("t2_done_cnt", done_cnt, 2);
        chk("t2_start_cnt", start_cnt, 2);

        // ap_continue held low for 4 cycles with ap_done high
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(1);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_done_held", done_cnt, 0);
        chk("t3_no_valid", lat_valid, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_last_lat", last_lat, 6);

        // zero-latency transaction in IDLE
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_last_lat", last_lat, 0);
        chk("t4_lat_valid", lat_valid, 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_min", min_lat, 0);
        chk("t4_err", err, 0);

        // finish while in WAIT_DONE
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_status_active", status, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_status_wait", status, 2);
        finish = 1'b1;
        idle(1);
        chk("t5_status_fin", status, 3);
        chk("t5_pulse", finish_pulse, 1);
        idle(1);
        chk("t5_pulse_once", finish_pulse, 0);
        finish = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t5_done_frozen", done_cnt, 0);
        chk("t5_no_valid", lat_valid, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        chk("t5_start_frozen", start_cnt, 1);
        chk("t5_status_sticky", status, 3);
        chk("t5_pulse_quiet", finish_pulse, 0);

        // reset mid-transaction, then a done with nothing tracked
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_no_valid", lat_valid, 0);
        chk("t6_done_cnt", done_cnt, 0);
        chk("t6_err_spur", err, ERR_SPUR);
        idle(3);
        chk("t6_err_sticky", err, ERR_SPUR);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t6_err_drop", err, ERR_BOTH);
        do_reset();
        chk("t6_err_cleared", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
